// File: rtl/proc_core_param_if.sv
// Handshake and bus bundle between the processor core and whatever feeds it
// instructions and immediates.
interface proc_core_param_if #(
    parameter int DATA_W = 16
);
    logic              run;
    logic [DATA_W-1:0] din;
    logic              done;
    logic [DATA_W-1:0] bus;
    logic              z_flag;

    modport master (output run, din, input done, bus, z_flag);
    modport slave  (input run, din, output done, bus, z_flag);
endinterface

// File: rtl/proc_core_param.sv
// Parametrised multicycle bus processor: step FSM, register file, A/G registers
// and a single one-hot shared bus multiplexer.
module pcp_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (!resetn)  q <= '0;
        else if (en)  q <= d;
    end
endmodule

module proc_core_param #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8
) (
    input  logic             clk,
    input  logic             resetn,
    proc_core_param_if.slave io
);
    localparam int RW = $clog2(NUM_REGS);
    localparam int IW = 3 + 2 * RW;

    typedef enum logic [1:0] {T0, T1, T2, T3} step_t;
    typedef enum logic [2:0] {
        OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_MVNZ, OP_RSV
    } op_t;

    step_t step, step_nxt;
    logic [IW-1:0] ir;
    logic [DATA_W-1:0] a, g, bus, alu;
    logic z;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs;

    logic                sel_din, sel_g, a_en, g_en, done;
    logic [NUM_REGS-1:0] sel_r, r_en;

    op_t           op;
    logic [RW-1:0] rx, ry;
    assign op = op_t'(ir[IW-1:IW-3]);
    assign rx = ir[2*RW-1:RW];
    assign ry = ir[RW-1:0];

    always_ff @(posedge clk) begin
        if (!resetn) step <= T0;
        else         step <= step_nxt;
    end

    always_comb begin
        step_nxt = step;
        done     = 1'b0;
        sel_din  = 1'b0;
        sel_g    = 1'b0;
        sel_r    = '0;
        r_en     = '0;
        a_en     = 1'b0;
        g_en     = 1'b0;
        case (step)
            T0: if (io.run) step_nxt = T1;
            T1: begin
                case (op)
                    OP_MV: begin
                        sel_r[ry] = 1'b1;
                        r_en[rx]  = 1'b1;
                        done      = 1'b1;
                        step_nxt  = T0;
                    end
                    OP_MVI: begin
                        sel_din  = 1'b1;
                        r_en[rx] = 1'b1;
                        done     = 1'b1;
                        step_nxt = T0;
                    end
                    OP_MVNZ: begin
                        sel_r[ry] = 1'b1;
                        r_en[rx]  = !z;
                        done      = 1'b1;
                        step_nxt  = T0;
                    end
                    OP_RSV: begin
                        done     = 1'b1;
                        step_nxt = T0;
                    end
                    default: begin
                        sel_r[rx] = 1'b1;
                        a_en      = 1'b1;
                        step_nxt  = T2;
                    end
                endcase
            end
            T2: begin
                sel_r[ry] = 1'b1;
                g_en      = 1'b1;
                step_nxt  = T3;
            end
            T3: begin
                sel_g    = 1'b1;
                r_en[rx] = 1'b1;
                done     = 1'b1;
                step_nxt = T0;
            end
            default: step_nxt = T0;
        endcase
    end

    // Selects are one-hot, so OR-ing the gated sources is the mux; idle bus is 0.
    always_comb begin
        bus = '0;
        if (sel_din) bus = bus | io.din;
        if (sel_g)   bus = bus | g;
        for (int i = 0; i < NUM_REGS; i++)
            if (sel_r[i]) bus = bus | regs[i];
    end

    always_comb begin
        case (op)
            OP_ADD:  alu = a + bus;
            OP_SUB:  alu = a - bus;
            OP_AND:  alu = a & bus;
            OP_XOR:  alu = a ^ bus;
            default: alu = '0;
        endcase
    end

    // z resets to 1 to stay consistent with G = 0.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ir <= '0;
            a  <= '0;
            g  <= '0;
            z  <= 1'b1;
        end else begin
            if (step == T0 && io.run) ir <= io.din[IW-1:0];
            if (a_en) a <= bus;
            if (g_en) begin
                g <= alu;
                z <= (alu == '0);
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_rf
        pcp_reg #(.W(DATA_W)) u_reg (
            .clk    (clk),
            .resetn (resetn),
            .en     (r_en[i]),
            .d      (bus),
            .q      (regs[i])
        );
    end

    assign io.done   = done;
    assign io.bus    = bus;
    assign io.z_flag = z;
endmodule

// File: tb/tb_proc_core_param.sv
// Scoreboard bench: a reference model predicts bus and z_flag at each done pulse;
// register contents are observed on the bus through mv Rn,Rn.
module tb_proc_core_param;
    localparam int DATA_W = 16;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    proc_core_param_if #(.DATA_W(DATA_W)) io ();

    proc_core_param #(.DATA_W(DATA_W), .NUM_REGS(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .io     (io)
    );

    typedef struct packed {
        logic [15:0] bus;
        logic        z;
    } sb_t;

    sb_t         sbq[$];
    logic [15:0] m_r[8];
    logic        m_z;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resetn && io.done) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sbq.pop_front();
                chk("done_bus", 32'(io.bus), 32'(e.bus));
                chk("done_z", 32'(io.z_flag), 32'(e.z));
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_r[i] = '0;
        m_z = 1'b1;
    endtask

    // Drives one instruction from a negedge in T0; returns at the negedge of the
    // following T0 cycle, leaving run high so calls chain back-to-back.
    task automatic issue(input logic [2:0] op, input int rx, input int ry, input logic [15:0] imm);
        sb_t         e;
        logic [15:0] res;
        logic [6:0]  hi;
        int          n;
        res = '0;
        case (op)
            3'd0: begin e.bus = m_r[ry]; m_r[rx] = m_r[ry]; end
            3'd1: begin e.bus = imm; m_r[rx] = imm; end
            3'd6: begin e.bus = m_r[ry]; if (!m_z) m_r[rx] = m_r[ry]; end
            3'd7: e.bus = '0;
            default: begin
                case (op)
                    3'd2: res = m_r[rx] + m_r[ry];
                    3'd3: res = m_r[rx] - m_r[ry];
                    3'd4: res = m_r[rx] & m_r[ry];
                    default: res = m_r[rx] ^ m_r[ry];
                endcase
                m_r[rx] = res;
                m_z = (res == '0);
                e.bus = res;
            end
        endcase
        e.z = m_z;
        sbq.push_back(e);
        hi = 7'($urandom);
        io.run = 1'b1;
        io.din = {hi, op, rx[2:0], ry[2:0]};
        @(posedge clk);
        #1 io.din = imm;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!io.done && n < 8);
        if (!io.done) chk("done_timeout", 32'd0, 32'd1);
        chk("latency", 32'(n), (op[2:1] == 2'b01 || op[2:1] == 2'b10) ? 32'd3 : 32'd1);
        @(negedge clk);
    endtask

    task automatic peek_all();
        for (int i = 0; i < 8; i++) issue(3'd0, i, i, 16'h0);
    endtask

    initial begin
        io.run = 1'b0;
        io.din = '0;
        model_reset();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_done", 32'(io.done), 32'd0);
            chk("idle_bus", 32'(io.bus), 32'd0);
            chk("idle_z", 32'(io.z_flag), 32'd1);
        end
        peek_all();

        issue(3'd1, 0, 0, 16'h0005);
        issue(3'd1, 1, 0, 16'hFFFF);
        issue(3'd1, 2, 0, 16'h1234);
        issue(3'd1, 4, 0, 16'h0004);

        issue(3'd2, 0, 1, 16'h0);
        issue(3'd3, 2, 2, 16'h0);

        issue(3'd6, 3, 0, 16'h0);
        issue(3'd5, 4, 0, 16'h0);
        issue(3'd4, 1, 0, 16'h0);
        issue(3'd6, 3, 1, 16'h0);
        peek_all();

        issue(3'd7, 3, 5, 16'h0);
        issue(3'd3, 5, 5, 16'h0);
        issue(3'd7, 6, 1, 16'hBEEF);
        issue(3'd1, 6, 0, 16'h0001);
        issue(3'd3, 5, 6, 16'h0);
        issue(3'd2, 1, 1, 16'h0);
        peek_all();
        io.run = 1'b0;
        repeat (2) @(negedge clk);

        // add R0,R1 interrupted by reset while in T2
        io.run = 1'b1;
        io.din = {7'h00, 3'd2, 3'd0, 3'd1};
        @(posedge clk);
        #1 io.run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t2_done", 32'(io.done), 32'd0);
        resetn = 1'b0;
        @(negedge clk);
        chk("rst_done", 32'(io.done), 32'd0);
        chk("rst_bus", 32'(io.bus), 32'd0);
        chk("rst_z", 32'(io.z_flag), 32'd1);
        resetn = 1'b1;
        model_reset();
        chk("rst_sb_empty", 32'(sbq.size()), 32'd0);
        peek_all();
        issue(3'd1, 7, 0, 16'h8001);
        issue(3'd2, 7, 7, 16'h0);
        issue(3'd7, 0, 0, 16'h0);
        peek_all();
        io.run = 1'b0;
        repeat (3) @(negedge clk);
        chk("end_sb_empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/proc_core_param.md
# proc_core_param

Parametrised multicycle processor core that generalises the fixed 9-bit, eight-register bus processor to a configurable data width and register count. It adds logic ops (`and`, `xor`) and a conditional move (`mvnz`) driven by a zero flag. It sits at the top of the datapath and fetches instructions and immediates from `Din` under a `run`/`done` handshake. Internally it has a step counter, a control FSM, a register file, the A and G registers, and a single shared bus multiplexer.

## Interface

- `DATA_W`, default 16: width of the bus, the registers and `Din`. Must be ≥ `IW`.
- `NUM_REGS`, default 8: number of general registers. Power of two, 2..16.
- Derived values, not overridable:
  - `RW` = clog2(`NUM_REGS`).
  - `IW` = 3 + 2·`RW`, which is 9 at the defaults.
- `clk`: input, 1 bit. The single clock. All state updates on the rising edge.
- `resetn`: input, 1 bit. Reset is synchronous and active-low.
- `run`: input, 1 bit. Start request, sampled only in step T0.
- `Din`: input, `DATA_W` bits. Carries the instruction in T0 and the immediate in T1 of `mvi`.
- `done`: output, 1 bit. High during the final step of each instruction.
- `bus`: output, `DATA_W` bits. Current value of the internal shared bus.
- `z_flag`: output, 1 bit. High when the last ALU result was zero.

## Operation

**Instruction layout**
- The instruction is taken from `Din[IW-1:0]`; upper bits are ignored.
- Fields in IR: opcode = `IR[IW-1:IW-3]`, Rx = `IR[2RW-1:RW]`, Ry = `IR[RW-1:0]`.

**Opcodes**
- 000 `mv` : Rx ← Ry.
- 001 `mvi`: Rx ← `Din`, where `Din` is sampled in T1.
- 010 `add`: Rx ← Rx + Ry.
- 011 `sub`: Rx ← Rx − Ry.
- 100 `and`: Rx ← Rx & Ry.
- 101 `xor`: Rx ← Rx ^ Ry.
- 110 `mvnz`: Rx ← Ry only if `z_flag` = 0.
- 111: reserved. Executes as a NOP and asserts `done` in T1.

**Step FSM (states T0, T1, T2, T3)**
- T0: if `run` = 1, IR ← `Din` and go to T1. Otherwise stay in T0. Nothing drives the bus.
- `mv`, `mvi`, `mvnz`, reserved: T1 is the final step. Go back to T0 after it.
- ALU ops:
  - T1: bus = Rx, A ← bus.
  - T2: bus = Ry, G ← A op bus, `z_flag` ← (result == 0).
  - T3: bus = G, Rx ← bus, `done` = 1. Go back to T0.
- `mv`/`mvnz` in T1: bus = Ry.
  - `mv` always writes Rx.
  - `mvnz` writes Rx only if `z_flag` = 0.
- `mvi` in T1: bus = `Din`, Rx ← bus.

**Bus multiplexer**
- One-hot select among `Din`, R0..R(`NUM_REGS`-1) and G.
- When no source is selected, bus = 0.

**Arithmetic**
- All results are modulo 2^`DATA_W`; there are no carry or overflow outputs.
- `sub` wraps: 0 − 1 = all ones.
- Only the ALU ops update `z_flag`. `mv`, `mvi` and `mvnz` leave it unchanged.

**Boundary conditions**
- Rx = Ry is legal. `add R1,R1` doubles R1. `sub R1,R1` gives 0 and sets `z_flag`.
- `mvnz` with `z_flag` = 1 performs no write but still asserts `done`.
- `run` is ignored outside T0. Holding `run` high chains instructions back-to-back.
- Reset mid-instruction:
  - Reset has priority over every write in that cycle.
  - The FSM returns to T0 and the in-flight instruction is abandoned with no register written.

## Timing

**Reset values**
- Step = T0.
- IR, A, G and all Rn = 0.
- `z_flag` = 1, consistent with G = 0.
- `done` = 0.
- `bus` = 0, because no driver is selected in T0.

**Outputs**
- `done` is a combinational decode of step and opcode. It is high for exactly one cycle per instruction.
- The destination register holds its new value from the cycle after `done`.

**Latency, counting from the T0 edge where `run` = 1**
- `mv`, `mvi`, `mvnz`, reserved: 2 cycles.
- ALU ops: 4 cycles.
- The next instruction can be fetched in the cycle immediately after `done`.

**Handshake**
- `Din` must hold the instruction at the T0 edge and the immediate at the `mvi` T1 edge.
- `Din` is don't-care at all other times.

## Test plan

Defaults apply: `DATA_W`=16, `NUM_REGS`=8.

1. Reset, then hold `run`=0 for 5 cycles.
   - R0..R7 = 0, `z_flag`=1, `done`=0, `bus`=0 throughout.
   - Step stays in T0.
2. `mvi R0,#0x0005` then `mvi R1,#0xFFFF`, back-to-back with `run` held high.
   - `done` pulses every 2 cycles.
   - `bus` = 0x0005, then 0xFFFF in the respective T1 cycles.
   - Final values: R0=5, R1=0xFFFF.
3. `add R0,R1` with R0=5, R1=0xFFFF.
   - `done` rises in the 4th cycle.
   - R0=0x0004, `z_flag`=0.
   - Then `sub R2,R2` with R2=0x1234 gives R2=0, `z_flag`=1.
4. `mvnz R3,R0` with `z_flag`=1 leaves R3=0.
   - Then `xor R4,R0` with R4=0x0004 gives R4=0 and `z_flag`=1.
   - Then `and R1,R0` with R0=4, R1=0xFFFF gives R1=4 and `z_flag`=0.
   - Then `mvnz R3,R1` gives R3=4.
5. Start `add R0,R1` and assert `resetn`=0 in T2.
   - Next cycle: all registers = 0, step T0, `done`=0, and no write to R0.
6. Reserved opcode 111 with `run`=1.
   - `done` pulses in T1.
   - All registers and `z_flag` are unchanged.
   - Upper `Din` bits [15:9] set to ones do not alter the decode of any instruction.
